io_ctrl: RTL and testbench

Memory-mapped I/O controller between the CPU load/store path and the UART plus performance counters. It decodes I/O-space reads and writes and returns registered read data. It sequences the UART ready/valid handshakes: it pops received bytes on reads and holds transmit bytes until the UART accepts them. It owns the cycle and retired-instruction counters and clears them on command.

---
 rtl/io_ctrl_if.sv | 28 ++
 rtl/io_ctrl.sv | 111 +++++++++++
 tb/tb_io_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/io_ctrl_if.sv
// rtl/io_ctrl_if.sv - CPU I/O-space bus and UART handshake signals for io_ctrl
interface io_ctrl_if;
    logic        io_re;
    logic        io_we;
    logic [7:0]  io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        inst_retire;
    logic [7:0]  uart_rx_data_out;
    logic        uart_rx_data_out_valid;
    logic        uart_rx_data_out_ready;
    logic [7:0]  uart_tx_data_in;
    logic        uart_tx_data_in_valid;
    logic        uart_tx_data_in_ready;

    // master: CPU pipeline plus UART side; slave: the controller
    modport master (
        output io_re, io_we, io_addr, io_wdata, inst_retire,
        output uart_rx_data_out, uart_rx_data_out_valid, uart_tx_data_in_ready,
        input  io_rdata, uart_rx_data_out_ready, uart_tx_data_in, uart_tx_data_in_valid
    );

    modport slave (
        input  io_re, io_we, io_addr, io_wdata, inst_retire,
        input  uart_rx_data_out, uart_rx_data_out_valid, uart_tx_data_in_ready,
        output io_rdata, uart_rx_data_out_ready, uart_tx_data_in, uart_tx_data_in_valid
    );
endinterface

// File: rtl/io_ctrl.sv
// rtl/io_ctrl.sv - memory-mapped I/O controller: UART handshakes, cycle/instret counters
module io_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    io_ctrl_if.slave  bus
);
    localparam logic [7:0] ADDR_STATUS = 8'h00;
    localparam logic [7:0] ADDR_RX     = 8'h04;
    localparam logic [7:0] ADDR_TX     = 8'h08;
    localparam logic [7:0] ADDR_CYC    = 8'h10;
    localparam logic [7:0] ADDR_INST   = 8'h14;
    localparam logic [7:0] ADDR_CLR    = 8'h18;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    tx_state_t            tx_state, tx_state_nxt;
    logic [7:0]           tx_byte, tx_byte_nxt;
    logic                 tx_valid;
    logic [CNT_WIDTH-1:0] cyc_count, inst_count;
    logic [31:0]          cyc_ext, inst_ext, rd_value, rdata_q;
    logic                 tx_wr, cnt_clr;

    assign tx_wr   = bus.io_we && (bus.io_addr == ADDR_TX);
    assign cnt_clr = bus.io_we && (bus.io_addr == ADDR_CLR);

    assign bus.uart_rx_data_out_ready = bus.io_re && (bus.io_addr == ADDR_RX) &&
                                        bus.uart_rx_data_out_valid;
    assign bus.uart_tx_data_in        = tx_byte;
    assign bus.uart_tx_data_in_valid  = tx_valid;
    assign bus.io_rdata               = rdata_q;

    generate
        if (CNT_WIDTH >= 32) begin : g_cnt_trunc
            assign cyc_ext  = cyc_count[31:0];
            assign inst_ext = inst_count[31:0];
        end else begin : g_cnt_zext
            assign cyc_ext  = {{(32-CNT_WIDTH){1'b0}}, cyc_count};
            assign inst_ext = {{(32-CNT_WIDTH){1'b0}}, inst_count};
        end
    endgenerate

    // Read data is decoded from pre-edge state, so same-cycle writes are not visible
    always_comb begin
        rd_value = 32'h0;
        case (bus.io_addr)
            ADDR_STATUS: rd_value = {30'h0, bus.uart_rx_data_out_valid, tx_state == TX_IDLE};
            ADDR_RX:     rd_value = {24'h0, bus.uart_rx_data_out};
            ADDR_CYC:    rd_value = cyc_ext;
            ADDR_INST:   rd_value = inst_ext;
            default:     rd_value = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'h0;
        end else if (bus.io_re) begin
            rdata_q <= rd_value;
        end
    end

    // Writes to the TX register while a byte is pending are dropped, not queued
    always_comb begin
        tx_state_nxt = tx_state;
        tx_byte_nxt  = tx_byte;
        tx_valid     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (tx_wr) begin
                    tx_byte_nxt  = bus.io_wdata[7:0];
                    tx_state_nxt = TX_SEND;
                end
            end
            TX_SEND: begin
                tx_valid = 1'b1;
                if (bus.uart_tx_data_in_ready) begin
                    tx_state_nxt = TX_IDLE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_byte  <= 8'h0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_byte  <= tx_byte_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_count  <= '0;
            inst_count <= '0;
        end else if (cnt_clr) begin
            cyc_count  <= '0;
            inst_count <= '0;
        end else begin
            cyc_count <= cyc_count + CNT_ONE;
            if (bus.inst_retire) begin
                inst_count <= inst_count + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_io_ctrl.sv
// tb/tb_io_ctrl.sv - scoreboard bench for io_ctrl with a 4-bit counter build
module tb_io_ctrl;
    logic clk;
    logic rst;
    io_ctrl_if bus ();

    io_ctrl #(.CNT_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    logic [31:0] exp_q[$];
    logic        mon_re;
    logic [31:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each accepted read presents io_rdata one edge later
    always @(posedge clk) begin
        mon_re = bus.io_re && !rst;
        #1;
        if (mon_re) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rdata_unexpected: got 0x%08h with no expected entry", bus.io_rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.io_rdata !== mon_exp) begin
                    n_fail++;
                    $display("FAIL rdata: got 0x%08h expected 0x%08h", bus.io_rdata, mon_exp);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_bus();
        bus.io_re = 1'b0;
        bus.io_we = 1'b0;
    endtask

    task automatic issue_read(input logic [7:0] addr, input logic [31:0] exp);
        bus.io_re   = 1'b1;
        bus.io_we   = 1'b0;
        bus.io_addr = addr;
        exp_q.push_back(exp);
        step();
        idle_bus();
    endtask

    task automatic issue_write(input logic [7:0] addr, input logic [31:0] data);
        bus.io_re    = 1'b0;
        bus.io_we    = 1'b1;
        bus.io_addr  = addr;
        bus.io_wdata = data;
        step();
        idle_bus();
    endtask

    localparam logic [9:0] RETIRE_PAT = 10'b1101101101;

    initial begin
        rst = 1'b1;
        bus.io_re = 1'b0;
        bus.io_we = 1'b0;
        bus.io_addr = 8'h0;
        bus.io_wdata = 32'h0;
        bus.inst_retire = 1'b0;
        bus.uart_rx_data_out = 8'h0;
        bus.uart_rx_data_out_valid = 1'b0;
        bus.uart_tx_data_in_ready = 1'b0;
        step();
        step();
        check("reset_rdata", bus.io_rdata, 32'h0);
        check("reset_tx_valid", {31'h0, bus.uart_tx_data_in_valid}, 32'h0);
        check("reset_tx_data", {24'h0, bus.uart_tx_data_in}, 32'h0);
        rst = 1'b0;

        // counters after reset release
        repeat (5) step();
        issue_read(8'h10, 32'd5);
        issue_read(8'h14, 32'd0);

        // RX path
        bus.uart_rx_data_out = 8'h5A;
        bus.uart_rx_data_out_valid = 1'b1;
        issue_read(8'h00, 32'h3);
        bus.io_re = 1'b1;
        bus.io_addr = 8'h04;
        #1;
        check("rx_ready_pulse", {31'h0, bus.uart_rx_data_out_ready}, 32'h1);
        exp_q.push_back(32'h0000005A);
        step();
        idle_bus();
        #1;
        check("rx_ready_low_after", {31'h0, bus.uart_rx_data_out_ready}, 32'h0);
        bus.uart_rx_data_out_valid = 1'b0;
        issue_read(8'h00, 32'h1);
        bus.uart_rx_data_out = 8'h33;
        bus.io_re = 1'b1;
        bus.io_addr = 8'h04;
        #1;
        check("rx_no_pop_when_empty", {31'h0, bus.uart_rx_data_out_ready}, 32'h0);
        exp_q.push_back(32'h00000033);
        step();
        idle_bus();

        // TX path: held while UART not ready, second write dropped
        bus.uart_tx_data_in_ready = 1'b0;
        issue_write(8'h08, 32'hFFFF_FF41);
        for (int i = 0; i < 3; i++) begin
            check("tx_valid_held", {31'h0, bus.uart_tx_data_in_valid}, 32'h1);
            check("tx_data_held", {24'h0, bus.uart_tx_data_in}, 32'h41);
            if (i == 0) issue_read(8'h00, 32'h0);
            else if (i == 1) issue_write(8'h08, 32'h42);
            else step();
        end
        check("tx_data_after_drop", {24'h0, bus.uart_tx_data_in}, 32'h41);
        bus.uart_tx_data_in_ready = 1'b1;
        step();
        bus.uart_tx_data_in_ready = 1'b0;
        check("tx_valid_drop", {31'h0, bus.uart_tx_data_in_valid}, 32'h0);
        issue_read(8'h00, 32'h1);

        // simultaneous read and write of 0x08: read returns 0, write takes effect
        bus.io_re = 1'b1;
        bus.io_we = 1'b1;
        bus.io_addr = 8'h08;
        bus.io_wdata = 32'h77;
        exp_q.push_back(32'h0);
        step();
        idle_bus();
        check("tx_rw_same_cycle_valid", {31'h0, bus.uart_tx_data_in_valid}, 32'h1);
        check("tx_rw_same_cycle_data", {24'h0, bus.uart_tx_data_in}, 32'h77);
        bus.uart_tx_data_in_ready = 1'b1;
        step();
        bus.uart_tx_data_in_ready = 1'b0;

        // retired-instruction count, clear precedence over increment
        for (int i = 0; i < 10; i++) begin
            bus.inst_retire = RETIRE_PAT[i];
            step();
        end
        bus.inst_retire = 1'b0;
        issue_read(8'h14, 32'd7);
        bus.inst_retire = 1'b1;
        issue_write(8'h18, 32'hDEAD_BEEF);
        bus.inst_retire = 1'b0;
        issue_read(8'h14, 32'd0);
        issue_read(8'h10, 32'd1);

        // wrap of the 4-bit cycle counter and unmapped/write-only reads
        issue_write(8'h18, 32'h0);
        repeat (15) step();
        issue_read(8'h10, 32'd15);
        issue_read(8'h20, 32'h0);
        issue_read(8'h10, 32'd1);
        issue_read(8'h08, 32'h0);
        issue_read(8'h10, 32'd3);
        issue_read(8'h18, 32'h0);

        // asynchronous reset mid-send
        issue_write(8'h08, 32'hC3);
        bus.uart_rx_data_out = 8'hA5;
        issue_read(8'h04, 32'h000000A5);
        step();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tx_valid", {31'h0, bus.uart_tx_data_in_valid}, 32'h0);
        check("async_rst_tx_data", {24'h0, bus.uart_tx_data_in}, 32'h0);
        check("async_rst_rdata", bus.io_rdata, 32'h0);
        check("async_rst_cyc", {28'h0, dut.cyc_count}, 32'h0);
        step();
        rst = 1'b0;
        step();
        step();
        issue_read(8'h10, 32'd2);

        step();
        step();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
